// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Stall/flush controller for the 5-stage RV32I pipeline. It covers
//             the hazards that forwarding cannot resolve:
//               - load-use dependencies: one-cycle bubble into ID/EX
//               - instruction/data memory wait: the whole pipe freezes
//               - EX redirect: the front end is squashed
//             A redirect that arrives while the pipe is frozen is latched and
//             replayed in the cycle the freeze releases.
//             Saturating counters record stall and flush cycles.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             id_rs*_s/_use   - source registers of the instruction in ID
//             ex_*            - destination info of the instruction in ID/EX
//             imem_*/dmem_*   - memory request levels and response strobes
//             br_flush        - EX-stage redirect
//             hold_all        - every pipeline register and the PC hold
//             hold_front      - PC and IF/ID hold
//             bubble_ex       - ID/EX loads a NOP
//             flush_front     - IF/ID and ID/EX squashed, PC takes redirect
//             state_o         - 0 RUN, 1 MEM_WAIT, 2 FLUSH_PEND
//             stall_cnt       - cycles with hold_all or hold_front
//             flush_cnt       - cycles with flush_front
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_s,
    input  logic [4:0]       id_rs2_s,
    input  logic             id_rs1_use,
    input  logic             id_rs2_use,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd_s,
    input  logic             ex_is_load,
    input  logic             ex_regf_we,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             br_flush,
    output logic             hold_all,
    output logic             hold_front,
    output logic             bubble_ex,
    output logic             flush_front,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] c_s_run        = 2'd0;
    localparam logic [1:0] c_s_mem_wait   = 2'd1;
    localparam logic [1:0] c_s_flush_pend = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_flush_pend;
    logic w_mem_stall;
    logic w_load_use;
    logic w_flush_req;
    logic w_hold_all;
    logic w_hold_front;
    logic w_bubble_ex;
    logic w_flush_front;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // The pending redirect lives in the state encoding itself.
    assign w_flush_pend = (r_state == c_s_flush_pend);

    // A response in the same cycle as its request is a zero-wait access,
    // and a response without a request cannot create a stall.
    assign w_mem_stall = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp);

    assign w_rs1_hit  = id_rs1_use & (id_rs1_s == ex_rd_s);
    assign w_rs2_hit  = id_rs2_use & (id_rs2_s == ex_rd_s);
    // x0 is never a real dependency.
    assign w_load_use = ex_valid & ex_is_load & ex_regf_we & (ex_rd_s != 5'd0)
                      & (w_rs1_hit | w_rs2_hit);

    assign w_flush_req = br_flush | w_flush_pend;

    // Priority: memory freeze, then redirect (which squashes the dependent
    // instruction and so overrides load-use), then load-use bubble.
    always_comb begin
        w_hold_all    = 1'b0;
        w_hold_front  = 1'b0;
        w_bubble_ex   = 1'b0;
        w_flush_front = 1'b0;
        if (rst) begin
            // everything quiet while in reset
        end else if (w_mem_stall) begin
            w_hold_all   = 1'b1;
            w_hold_front = 1'b1;
        end else if (w_flush_req) begin
            w_flush_front = 1'b1;
        end else if (w_load_use) begin
            w_hold_front = 1'b1;
            w_bubble_ex  = 1'b1;
        end
    end

    assign hold_all    = w_hold_all;
    assign hold_front  = w_hold_front;
    assign bubble_ex   = w_bubble_ex;
    assign flush_front = w_flush_front;

    // Registered values are masked during reset so that every output reads 0
    // even in the cycle before the first reset edge has been seen.
    assign state_o   = rst ? 2'd0 : r_state;
    assign stall_cnt = rst ? '0 : r_stall_cnt;
    assign flush_cnt = rst ? '0 : r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_s_run;
        end else begin
            case (r_state)
                c_s_run: begin
                    if (w_mem_stall && br_flush) begin
                        r_state <= c_s_flush_pend;
                    end else if (w_mem_stall) begin
                        r_state <= c_s_mem_wait;
                    end else begin
                        r_state <= c_s_run;
                    end
                end
                c_s_mem_wait: begin
                    if (w_mem_stall && br_flush) begin
                        r_state <= c_s_flush_pend;
                    end else if (!w_mem_stall) begin
                        r_state <= c_s_run;
                    end else begin
                        r_state <= c_s_mem_wait;
                    end
                end
                c_s_flush_pend: begin
                    // The release cycle drives flush_front from the pending
                    // flag; further br_flush during the wait is absorbed here.
                    if (!w_mem_stall) begin
                        r_state <= c_s_run;
                    end else begin
                        r_state <= c_s_flush_pend;
                    end
                end
                default: begin
                    r_state <= c_s_run;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((w_hold_all || w_hold_front) && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_front && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline stall/flush controller for the 5-stage RV32I pipeline.
- Handles the hazards that forwarding cannot resolve:
  - load-use dependencies (bubble insertion);
  - instruction/data memory wait (whole-pipe freeze);
  - EX-stage branch redirects (front-end squash). A redirect that arrives during a freeze is latched and replayed when the freeze ends.
- Drives the hold, bubble and flush enables of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
CNT_W, 32, width of the stall_cnt and flush_cnt performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_rs1_s  in  5  rs1 index of the instruction in ID
id_rs2_s  in  5  rs2 index of the instruction in ID
id_rs1_use  in  1  ID instruction reads rs1
id_rs2_use  in  1  ID instruction reads rs2
ex_valid  in  1  ID/EX register holds a valid instruction
ex_rd_s  in  5  rd index in ID/EX
ex_is_load  in  1  ID/EX instruction is a load
ex_regf_we  in  1  ID/EX instruction writes the register file
imem_req  in  1  fetch request outstanding (level, held until response)
imem_resp  in  1  instruction memory response this cycle
dmem_req  in  1  MEM-stage access outstanding (level, held until response)
dmem_resp  in  1  data memory response this cycle
br_flush  in  1  EX redirect (mispredict or jump)
hold_all  out  1  all pipeline registers and PC hold
hold_front  out  1  PC and IF/ID hold
bubble_ex  out  1  ID/EX loads a NOP (valid=0)
flush_front  out  1  IF/ID and ID/EX squashed; PC takes the redirect target
state_o  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 FLUSH_PEND
stall_cnt  out  CNT_W  cycles with hold_all or hold_front asserted
flush_cnt  out  CNT_W  flush_front assertions

Behaviour:
Reset:
- rst sampled on the clk edge.
- state RUN, flush_pend=0, both counters 0.
- All outputs are 0 while rst=1, whatever the other inputs are.

Derived signals (combinational):
- mem_stall = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp).
- load_use = ex_valid & ex_is_load & ex_regf_we & (ex_rd_s!=0) & ((id_rs1_use & id_rs1_s==ex_rd_s) | (id_rs2_use & id_rs2_s==ex_rd_s)).
- flush_req = br_flush | flush_pend.

Output priority, highest first:
1. mem_stall:
   - hold_all=1, hold_front=1, bubble_ex=0, flush_front=0.
   - If br_flush=1, set flush_pend at the edge.
2. flush_req:
   - flush_front=1; hold and bubble outputs are 0.
   - The load-use stall is suppressed because the dependent instruction is squashed.
   - flush_pend clears at the edge.
3. load_use:
   - hold_front=1, bubble_ex=1, hold_all=0.
   - Lasts one cycle: the load then advances to MEM and load_use drops without further action.
4. Otherwise all outputs are 0.

FSM (next state computed from the current cycle's inputs):
- RUN:
  - mem_stall & ~br_flush -> MEM_WAIT.
  - mem_stall & br_flush -> FLUSH_PEND.
  - otherwise stay in RUN.
- MEM_WAIT:
  - mem_stall & br_flush -> FLUSH_PEND.
  - ~mem_stall -> RUN.
- FLUSH_PEND:
  - ~mem_stall -> RUN; that same cycle flush_front=1.
  - otherwise stay in FLUSH_PEND.
- state_o=2 exactly when flush_pend=1.

Memory responses:
- imem_resp and dmem_resp arriving in the same cycle: both waits end; the stall releases that cycle.
- A response arriving in the same cycle as its request is a zero-wait access: no stall.
- A response with no request is ignored.

Redirects:
- br_flush held across several stall cycles produces exactly one flush_front, in the release cycle.
- A pulse of br_flush during a stall is never lost.

Counters:
- stall_cnt increments on every cycle with hold_all|hold_front.
- flush_cnt increments on every cycle with flush_front.
- Both saturate at 2^CNT_W-1 and do not wrap.

Reset mid-operation:
- A stall or pending flush is dropped: the next cycle is RUN and all outputs are 0.

Latency:
- All hazard outputs are combinational from the inputs and the state, valid in the same cycle.
- Only flush_pend, the state and the counters are registered.

Test Plan:
- Load-use: ex lw x5 (ex_valid=1, ex_is_load=1, ex_regf_we=1), ID add reading x5 via rs1 -> one cycle hold_front=1, bubble_ex=1, stall_cnt 0->1; with rs2=x5 only, same result; with ex_rd_s=0, no stall.
- dmem wait: dmem_req=1 for 3 cycles, dmem_resp in the 3rd -> hold_all=1 for exactly 2 cycles, state_o 1,1,0, stall_cnt=2.
- Flush during stall: imem_req held, br_flush pulsed one cycle at wait cycle 1, imem_resp 4 cycles later -> state_o=2 until release; flush_front=1 only in the imem_resp cycle; flush_cnt=1.
- Flush with load-use in the same cycle, no mem stall -> flush_front=1, hold_front=0, bubble_ex=0.
- Simultaneous imem/dmem waits, responses in different cycles (imem at cycle 2, dmem at cycle 4) -> hold_all stays 1 until cycle 4, where it deasserts.
- Reset during FLUSH_PEND -> next cycle state_o=0, all outputs 0, counters 0; saturation: preload near max (CNT_W=4) and stall 20 cycles -> stall_cnt=15.
